// File: rtl/lts_capture_sequencer.sv
// LTS capture sequencer: arms the LTS extractor, buffers one frame, checks
// its length, then replays well-formed frames onto the CSI stream.
// Both streams use AXI-Stream handshakes: a beat transfers on a rising edge
// where tvalid and tready are both high. A producer never drops tvalid, and
// never changes tdata or tlast, until that beat has transferred.
module lts_capture_sequencer #(
  parameter int FRAME_LEN      = 128,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int HOLDOFF_CYCLES = 1024
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        arm_in,
  input  logic        continuous_in,
  input  logic        lts_axis_tvalid,
  input  logic        lts_axis_tlast,
  input  logic [31:0] lts_axis_tdata,
  output logic        lts_axis_tready,
  output logic        extractor_rst_out,
  output logic        csi_axis_tvalid,
  output logic        csi_axis_tlast,
  output logic [31:0] csi_axis_tdata,
  input  logic        csi_axis_tready,
  output logic [15:0] frame_cnt_out,
  output logic [15:0] drop_cnt_out,
  output logic [2:0]  state_out
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [AW:0]   LP_LAST_WR = (AW+1)'(FRAME_LEN - 1);
  localparam logic [AW-1:0] LP_LAST_RD = AW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] LP_TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] LP_HO_LAST = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_FILL    = 3'd2,
    S_DISCARD = 3'd3,
    S_DRAIN   = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [AW:0]     r_wr_cnt;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   w_rd_addr;
  logic [TW-1:0]   r_idle_cnt;
  logic [HW-1:0]   r_hold_cnt;
  logic [15:0]     r_frame_cnt;
  logic [15:0]     r_drop_cnt;
  logic [31:0]     r_mem [FRAME_LEN];
  logic [31:0]     r_mem_q;
  logic            w_wr_en;
  logic            w_drop_inc;
  logic            w_frame_inc;
  logic            w_in_hs;

  assign w_in_hs        = lts_axis_tvalid && lts_axis_tready;
  assign csi_axis_tdata = (r_state == S_DRAIN) ? r_mem_q : 32'd0;
  assign frame_cnt_out  = r_frame_cnt;
  assign drop_cnt_out   = r_drop_cnt;
  assign state_out      = r_state;

  // Read address runs one ahead on a handshake so the 1-cycle RAM keeps
  // pace with a streaming sink; on a stall it re-reads the same word.
  assign w_rd_addr = (r_state == S_DRAIN && csi_axis_tready) ? r_rd_ptr + 1'b1 : r_rd_ptr;

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_next_state;
  end

  // Next-state decode and state-driven outputs.
  always_comb begin
    w_next_state      = r_state;
    lts_axis_tready   = 1'b0;
    extractor_rst_out = 1'b1;
    csi_axis_tvalid   = 1'b0;
    csi_axis_tlast    = 1'b0;
    w_wr_en           = 1'b0;
    w_drop_inc        = 1'b0;
    w_frame_inc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm_in || continuous_in) w_next_state = S_ARMED;
      end
      S_ARMED: begin
        lts_axis_tready   = 1'b1;
        extractor_rst_out = 1'b0;
        if (lts_axis_tvalid) begin
          if (lts_axis_tlast) begin
            w_drop_inc   = 1'b1;
            w_next_state = S_HOLDOFF;
          end else begin
            w_wr_en      = 1'b1;
            w_next_state = S_FILL;
          end
        end
      end
      S_FILL: begin
        lts_axis_tready   = 1'b1;
        extractor_rst_out = 1'b0;
        if (lts_axis_tvalid) begin
          w_wr_en = 1'b1;
          if (r_wr_cnt == LP_LAST_WR) begin
            if (lts_axis_tlast) begin
              w_next_state = S_DRAIN;
            end else begin
              w_drop_inc   = 1'b1;
              w_next_state = S_DISCARD;
            end
          end else if (lts_axis_tlast) begin
            w_drop_inc   = 1'b1;
            w_next_state = S_HOLDOFF;
          end
        end else if (r_idle_cnt == LP_TO_LAST) begin
          w_drop_inc   = 1'b1;
          w_next_state = S_HOLDOFF;
        end
      end
      S_DISCARD: begin
        lts_axis_tready   = 1'b1;
        extractor_rst_out = 1'b0;
        // Frame was already counted as dropped when it overran.
        if (lts_axis_tvalid) begin
          if (lts_axis_tlast) w_next_state = S_HOLDOFF;
        end else if (r_idle_cnt == LP_TO_LAST) begin
          w_next_state = S_HOLDOFF;
        end
      end
      S_DRAIN: begin
        csi_axis_tvalid = 1'b1;
        csi_axis_tlast  = (r_rd_ptr == LP_LAST_RD);
        if (csi_axis_tready && r_rd_ptr == LP_LAST_RD) begin
          w_frame_inc  = 1'b1;
          w_next_state = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (r_hold_cnt == LP_HO_LAST)
          w_next_state = continuous_in ? S_ARMED : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Pointers, idle/holdoff timers and saturating statistics counters.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_wr_cnt    <= '0;
      r_rd_ptr    <= '0;
      r_idle_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_wr_en)                r_wr_cnt <= r_wr_cnt + 1'b1;
      else if (r_state != S_FILL) r_wr_cnt <= '0;

      if (r_state == S_DRAIN) begin
        if (csi_axis_tready) r_rd_ptr <= r_rd_ptr + 1'b1;
      end else begin
        r_rd_ptr <= '0;
      end

      if ((r_state == S_FILL || r_state == S_DISCARD) && !w_in_hs)
        r_idle_cnt <= r_idle_cnt + 1'b1;
      else
        r_idle_cnt <= '0;

      if (r_state == S_HOLDOFF) r_hold_cnt <= r_hold_cnt + 1'b1;
      else                      r_hold_cnt <= '0;

      if (w_frame_inc && r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_drop_inc && r_drop_cnt != 16'hFFFF)   r_drop_cnt  <= r_drop_cnt + 16'd1;
    end
  end

  // Frame buffer: synchronous write, registered read.
  always_ff @(posedge clk_in) begin
    if (w_wr_en) r_mem[r_wr_cnt[AW-1:0]] <= lts_axis_tdata;
    r_mem_q <= r_mem[w_rd_addr];
  end

endmodule

// File: tb/tb_lts_capture_sequencer.sv
// Testbench for lts_capture_sequencer: directed frames in, scoreboarded CSI out.
module tb_lts_capture_sequencer;

  localparam int FRAME_LEN = 128;
  localparam int TIMEOUT   = 4096;
  localparam int HOLD      = 1024;
  localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_FILL = 3'd2,
                         S_DISCARD = 3'd3, S_DRAIN = 3'd4, S_HOLDOFF = 3'd5;

  logic        clk_in;
  logic        rst_n_in;
  logic        arm_in;
  logic        continuous_in;
  logic        lts_axis_tvalid;
  logic        lts_axis_tlast;
  logic [31:0] lts_axis_tdata;
  logic        lts_axis_tready;
  logic        extractor_rst_out;
  logic        csi_axis_tvalid;
  logic        csi_axis_tlast;
  logic [31:0] csi_axis_tdata;
  logic        csi_axis_tready;
  logic [15:0] frame_cnt_out;
  logic [15:0] drop_cnt_out;
  logic [2:0]  state_out;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          hs_cnt   = 0;
  int          hs0;
  logic        bp_en    = 1'b0;
  logic [32:0] exp_q[$];

  lts_capture_sequencer #(
    .FRAME_LEN(FRAME_LEN), .TIMEOUT_CYCLES(TIMEOUT), .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .arm_in(arm_in), .continuous_in(continuous_in),
    .lts_axis_tvalid(lts_axis_tvalid), .lts_axis_tlast(lts_axis_tlast),
    .lts_axis_tdata(lts_axis_tdata), .lts_axis_tready(lts_axis_tready),
    .extractor_rst_out(extractor_rst_out),
    .csi_axis_tvalid(csi_axis_tvalid), .csi_axis_tlast(csi_axis_tlast),
    .csi_axis_tdata(csi_axis_tdata), .csi_axis_tready(csi_axis_tready),
    .frame_cnt_out(frame_cnt_out), .drop_cnt_out(drop_cnt_out), .state_out(state_out)
  );

  // Clock and downstream ready (30% duty when backpressure is enabled).
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    csi_axis_tready = 1'b1;
    forever begin
      @(posedge clk_in); #1;
      csi_axis_tready = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on every CSI handshake and checks stall stability.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [32:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk_in);
      if (prev_stall) begin
        check("stall_valid", csi_axis_tvalid, 1'b1);
        check("stall_data", csi_axis_tdata, prev_data);
        check("stall_last", csi_axis_tlast, prev_last);
      end
      if (csi_axis_tvalid && csi_axis_tready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no output at %0t", csi_axis_tdata, $time);
        end else begin
          e = exp_q.pop_front();
          check("csi_data", csi_axis_tdata, e[31:0]);
          check("csi_last", csi_axis_tlast, e[32]);
        end
      end
      prev_stall = csi_axis_tvalid && !csi_axis_tready;
      prev_data  = csi_axis_tdata;
      prev_last  = csi_axis_tlast;
    end
  end

  task automatic push_good();
    for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back({(i == FRAME_LEN - 1), 32'(i)});
  endtask

  task automatic pulse_arm();
    @(posedge clk_in); #1;
    arm_in = 1'b1;
    @(posedge clk_in); #1;
    arm_in = 1'b0;
  endtask

  // Sends n beats with data start+i; last_at is the 1-based tlast beat (0 = none).
  task automatic send_frame(input int start, input int n, input int last_at, input int arm_at);
    @(posedge clk_in); #1;
    for (int i = 0; i < n; i++) begin
      int waited;
      waited          = 0;
      arm_in          = (i == arm_at);
      lts_axis_tvalid = 1'b1;
      lts_axis_tdata  = 32'(start + i);
      lts_axis_tlast  = (i + 1 == last_at);
      @(negedge clk_in);
      while (!lts_axis_tready && waited < 5000) begin
        waited++;
        @(negedge clk_in);
      end
      if (!lts_axis_tready) begin
        n_checks++;
        $display("FAIL beat_accept: got tready=0 after %0d cycles, expected 1", waited);
      end
      @(posedge clk_in); #1;
      lts_axis_tvalid = 1'b0;
      lts_axis_tlast  = 1'b0;
    end
    arm_in = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, input string name);
    int n;
    n = 0;
    @(negedge clk_in);
    while (state_out !== s && n < bound) begin
      n++;
      @(negedge clk_in);
    end
    check(name, state_out, s);
  endtask

  // Called at the first negedge in HOLDOFF; checks exact holdoff length.
  task automatic check_holdoff(input logic [2:0] after_s);
    repeat (HOLD - 1) @(posedge clk_in);
    @(negedge clk_in);
    check("holdoff_hold", state_out, S_HOLDOFF);
    check("holdoff_ext_rst", extractor_rst_out, 1'b1);
    @(posedge clk_in);
    @(negedge clk_in);
    check("holdoff_exit", state_out, after_s);
  endtask

  initial begin
    rst_n_in = 1'b0; arm_in = 1'b0; continuous_in = 1'b0;
    lts_axis_tvalid = 1'b0; lts_axis_tlast = 1'b0; lts_axis_tdata = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_state", state_out, S_IDLE);
    check("rst_csi_valid", csi_axis_tvalid, 1'b0);
    check("rst_csi_last", csi_axis_tlast, 1'b0);
    check("rst_csi_data", csi_axis_tdata, 32'd0);
    check("rst_lts_ready", lts_axis_tready, 1'b0);
    check("rst_ext_rst", extractor_rst_out, 1'b1);
    check("rst_frame_cnt", frame_cnt_out, 16'd0);
    check("rst_drop_cnt", drop_cnt_out, 16'd0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;

    // Single-shot good frame, with a stray arm pulse mid-frame that must be ignored.
    pulse_arm();
    @(negedge clk_in);
    check("armed_state", state_out, S_ARMED);
    check("armed_ext_rst", extractor_rst_out, 1'b0);
    check("armed_ready", lts_axis_tready, 1'b1);
    push_good();
    hs0 = hs_cnt;
    send_frame(0, FRAME_LEN, FRAME_LEN, 50);
    @(negedge clk_in);
    check("drain_state", state_out, S_DRAIN);
    check("drain_ext_rst", extractor_rst_out, 1'b1);
    check("drain_ready", lts_axis_tready, 1'b0);
    wait_state(S_HOLDOFF, 400, "good_to_holdoff");
    check("good_valid_after", csi_axis_tvalid, 1'b0);
    check("good_frame_cnt", frame_cnt_out, 16'd1);
    check("good_drop_cnt", drop_cnt_out, 16'd0);
    check("good_handshakes", 32'(hs_cnt - hs0), 32'd128);
    check("good_queue_empty", 32'(exp_q.size()), 32'd0);
    check_holdoff(S_IDLE);
    check("idle_ext_rst", extractor_rst_out, 1'b1);

    // Short frame: tlast on beat 64.
    pulse_arm();
    send_frame(0, 64, 64, -1);
    @(negedge clk_in);
    check("short_state", state_out, S_HOLDOFF);
    check("short_drop_cnt", drop_cnt_out, 16'd2 - 16'd1);
    check("short_valid", csi_axis_tvalid, 1'b0);
    check_holdoff(S_IDLE);

    // Long frame: 200 beats, tlast on beat 200, counted once.
    pulse_arm();
    send_frame(0, FRAME_LEN, 0, -1);
    @(negedge clk_in);
    check("long_discard", state_out, S_DISCARD);
    check("long_drop_cnt", drop_cnt_out, 16'd2);
    check("long_ready", lts_axis_tready, 1'b1);
    send_frame(FRAME_LEN, 72, 72, -1);
    @(negedge clk_in);
    check("long_state", state_out, S_HOLDOFF);
    check("long_drop_once", drop_cnt_out, 16'd2);
    check("long_frame_cnt", frame_cnt_out, 16'd1);
    check_holdoff(S_IDLE);

    // Good frame under random downstream backpressure.
    bp_en = 1'b1;
    pulse_arm();
    push_good();
    hs0 = hs_cnt;
    send_frame(0, FRAME_LEN, FRAME_LEN, -1);
    @(negedge clk_in);
    check("bp_drain_state", state_out, S_DRAIN);
    wait_state(S_HOLDOFF, 3000, "bp_to_holdoff");
    bp_en = 1'b0;
    check("bp_frame_cnt", frame_cnt_out, 16'd2);
    check("bp_drop_cnt", drop_cnt_out, 16'd2);
    check("bp_handshakes", 32'(hs_cnt - hs0), 32'd128);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    check_holdoff(S_IDLE);

    // Timeout: tvalid stops after beat 10.
    pulse_arm();
    send_frame(0, 10, 0, -1);
    repeat (TIMEOUT - 1) @(posedge clk_in);
    @(negedge clk_in);
    check("to_before", state_out, S_FILL);
    @(posedge clk_in);
    @(negedge clk_in);
    check("to_state", state_out, S_HOLDOFF);
    check("to_drop_cnt", drop_cnt_out, 16'd3);
    check_holdoff(S_IDLE);

    // Continuous mode: three good frames with automatic re-arm.
    continuous_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_good();
      send_frame(0, FRAME_LEN, FRAME_LEN, -1);
      wait_state(S_HOLDOFF, 400, "cont_to_holdoff");
      check("cont_frame_cnt", frame_cnt_out, 16'(3 + k));
      check("cont_queue_empty", 32'(exp_q.size()), 32'd0);
      check_holdoff(S_ARMED);
      check("cont_ext_rst", extractor_rst_out, 1'b0);
    end

    // Reset in the middle of a fill.
    send_frame(0, 20, 0, -1);
    @(negedge clk_in);
    check("pre_rst_fill", state_out, S_FILL);
    @(posedge clk_in); #1;
    rst_n_in      = 1'b0;
    continuous_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    check("mid_rst_state", state_out, S_IDLE);
    check("mid_rst_frame_cnt", frame_cnt_out, 16'd0);
    check("mid_rst_drop_cnt", drop_cnt_out, 16'd0);
    check("mid_rst_ext_rst", extractor_rst_out, 1'b1);
    check("mid_rst_valid", csi_axis_tvalid, 1'b0);
    check("mid_rst_ready", lts_axis_tready, 1'b0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;

    // Clearing continuous mid-capture finishes the frame, then idles.
    continuous_in = 1'b1;
    push_good();
    send_frame(0, 50, 0, -1);
    continuous_in = 1'b0;
    send_frame(50, FRAME_LEN - 50, FRAME_LEN - 50, -1);
    wait_state(S_HOLDOFF, 400, "clr_to_holdoff");
    check("clr_frame_cnt", frame_cnt_out, 16'd1);
    check("clr_drop_cnt", drop_cnt_out, 16'd0);
    check_holdoff(S_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lts_capture_sequencer.md
Name: lts_capture_sequencer

Overview:
- Controls capture of LTS frames from the LTS extractor into the CSI path.
- Holds the extractor in reset until software arms a capture, then stores one frame in an internal buffer and checks that its length is correct.
- Forwards only well-formed frames downstream. Drops malformed or stalled frames and counts them.
- Applies a holdoff period between captures, and supports single-shot and continuous modes.

Parameters:
- FRAME_LEN, 128, beats per valid LTS frame (two 64-sample LTS); must be a power of 2 and at least 2.
- TIMEOUT_CYCLES, 4096, idle cycles allowed mid-frame (FILL/DISCARD) before the frame is aborted.
- HOLDOFF_CYCLES, 1024, cycles the extractor is held in reset after each capture attempt; must be at least 1.

Ports:
- clk_in  in  1  clock; only clock domain.
- rst_n_in  in  1  synchronous reset, active-low.
- arm_in  in  1  single-cycle pulse that requests one capture.
- continuous_in  in  1  level; 1 = re-arm automatically after each holdoff.
- lts_axis_tvalid  in  1  extractor stream valid.
- lts_axis_tlast  in  1  extractor end of frame.
- lts_axis_tdata  in  32  {Q[15:0], I[15:0]}, I on the LSBs.
- lts_axis_tready  out  1  sequencer ready to accept extractor data.
- extractor_rst_out  out  1  active-high reset to the extractor.
- csi_axis_tvalid  out  1  output stream valid.
- csi_axis_tlast  out  1  high on the last output beat of a frame.
- csi_axis_tdata  out  32  buffered sample, same packing as the input.
- csi_axis_tready  in  1  downstream ready.
- frame_cnt_out  out  16  frames forwarded; saturates at 0xFFFF.
- drop_cnt_out  out  16  frames dropped; saturates at 0xFFFF.
- state_out  out  3  current state encoding, for LED/debug.

Behaviour:
- Reset (rst_n_in=0 at a clock edge) forces the following; the outputs below are combinational from state, so they take these values during reset.
  - state = IDLE; all counters and pointers = 0.
  - csi_axis_tvalid = 0, csi_axis_tlast = 0, csi_axis_tdata = 0.
  - lts_axis_tready = 0; extractor_rst_out = 1.
- A reset mid-frame or mid-drain abandons the frame. It is not counted as a drop.
- Buffer: FRAME_LEN x 32 single-port-write / single-port-read RAM with 1-cycle read latency.
- Write pointer wr_cnt counts from 0 to FRAME_LEN.
- States (state_out encoding): IDLE=0, ARMED=1, FILL=2, DISCARD=3, DRAIN=4, HOLDOFF=5.
- IDLE:
  - extractor_rst_out=1; lts_axis_tready=0.
  - arm_in=1 or continuous_in=1 -> ARMED.
- ARMED:
  - extractor_rst_out=0; lts_axis_tready=1.
  - First accepted beat writes mem[0], sets wr_cnt=1 -> FILL.
  - An accepted beat with tlast=1 in ARMED is a short frame: drop_cnt+1 -> HOLDOFF.
  - No timeout applies in ARMED.
- FILL:
  - lts_axis_tready=1; each accepted beat writes mem[wr_cnt] and increments wr_cnt.
  - Accepted beat with tlast=1:
    - If this is beat number FRAME_LEN (wr_cnt==FRAME_LEN-1 before the write) -> DRAIN.
    - Otherwise (short frame): drop_cnt+1 -> HOLDOFF.
  - Beat number FRAME_LEN accepted without tlast (long frame): drop_cnt+1 -> DISCARD.
  - Idle counter resets on every accepted beat. When it reaches TIMEOUT_CYCLES: drop_cnt+1 -> HOLDOFF.
- DISCARD:
  - lts_axis_tready=1; beats are accepted and not stored.
  - Accepted tlast -> HOLDOFF.
  - Timeout -> HOLDOFF with no further drop count (the frame was already counted once).
- DRAIN:
  - lts_axis_tready=0; extractor_rst_out=1.
  - Streams mem[0..FRAME_LEN-1] in order. csi_axis_tlast=1 only on index FRAME_LEN-1.
  - First tvalid must assert no later than 2 cycles after entering DRAIN.
  - With csi_axis_tready held high, one beat per cycle with no bubbles.
  - AXIS rules: tdata and tlast stay stable while tvalid=1 and tready=0; tvalid never drops before the handshake.
  - Last handshake: frame_cnt+1 -> HOLDOFF. The next cycle has csi_axis_tvalid=0.
- HOLDOFF:
  - extractor_rst_out=1; lts_axis_tready=0.
  - After exactly HOLDOFF_CYCLES cycles in HOLDOFF: continuous_in=1 -> ARMED, else -> IDLE.
- arm_in outside IDLE is ignored and not queued.
- Clearing continuous_in mid-capture finishes the current capture, then goes to IDLE.
- Counters saturate at 0xFFFF and never wrap.
- Simultaneous tlast and timeout on the same cycle: the accepted beat wins and the timeout is ignored.

Test Plan:
- Single-shot good frame: pulse arm_in; send 128 beats with data = index, tlast on beat 128; tready=1. Required: csi emits 0..127 in order, tlast on 127, frame_cnt=1, drop_cnt=0. Then HOLDOFF for 1024 cycles -> IDLE with extractor_rst_out=1.
- Short frame: tlast on beat 64. Required: no csi_axis_tvalid, drop_cnt=1, HOLDOFF then IDLE.
- Long frame: 200 beats, tlast on 200. Required: DISCARD from beat 129 to beat 200, drop_cnt=1 (counted once), no output.
- Backpressure: random csi_axis_tready at 30% duty on a good frame. Required: data intact, tdata and tlast stable while stalled, exactly 128 handshakes.
- Timeout: stop tvalid after beat 10 of a frame. Required: after 4096 idle cycles, drop_cnt+1 and state_out=5.
- Continuous mode with reset: continuous_in=1, three good frames -> frame_cnt=3, automatic re-arm after each holdoff. Then assert rst_n_in=0 during FILL. Required: IDLE, counters 0, extractor_rst_out=1, csi_axis_tvalid=0.
